// File: rtl/sti_deserializer.sv
// STI link receiver: recovers one 16-bit payload per serial frame (8/16/24/32 bits); po_valid one clock after the last bit; no backpressure.
// Optional saturating frame counter output when STI_RX_FRAME_CNT_EN is defined.
module sti_deserializer #(
  parameter int DW = 16,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          si_data,
  input  logic          si_valid,
  input  logic [1:0]    cfg_length,
  input  logic          cfg_fill,
  input  logic          cfg_msb,
  input  logic          cfg_low,
  output logic [DW-1:0] po_data,
  output logic          po_valid,
  output logic          pad_err,
  output logic          trunc_err,
  output logic          overrun_err,
  output logic          busy
`ifdef STI_RX_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t          state, state_d;
  logic [31:0]     shreg;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_q;
  logic [1:0]      len_q;
  logic            fill_q, msb_q, low_q;
  logic            gap_seen;
  logic            start, store, done, trunc, ovr;
  logic [16:0]     ext;

  function automatic logic [CW-1:0] frame_bits(input logic [1:0] len);
    return CW'({len, 3'b000}) + CW'(8);
  endfunction

  // Bits are placed directly at their final frame position, so no reversal is needed at the end.
  function automatic logic [31:0] bit_mask(input logic msb, input logic [1:0] len,
                                           input logic [CW-1:0] idx, input logic d);
    logic [CW-1:0] pos;
    pos = msb ? (frame_bits(len) - CW'(1) - idx) : idx;
    return {31'b0, d} << pos;
  endfunction

  function automatic logic [16:0] extract(input logic [31:0] f, input logic [1:0] len,
                                          input logic fill, input logic low);
    logic [16:0] r;
    case (len)
      2'd0:    r = {1'b0, (low ? {f[7:0], 8'h00} : {8'h00, f[7:0]})};
      2'd1:    r = {1'b0, f[15:0]};
      2'd2:    r = fill ? {|f[7:0], f[23:8]}   : {|f[23:16], f[15:0]};
      default: r = fill ? {|f[15:0], f[31:16]} : {|f[31:16], f[15:0]};
    endcase
    return r;
  endfunction

  assign n_q  = frame_bits(len_q);
  assign ext  = extract(shreg, len_q, fill_q, low_q);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    store   = 1'b0;
    done    = 1'b0;
    trunc   = 1'b0;
    ovr     = 1'b0;
    case (state)
      IDLE: begin
        if (si_valid) begin
          start   = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (cnt == n_q) begin
          // A bit arriving on the completion cycle is already the first extra bit.
          done    = 1'b1;
          ovr     = si_valid;
          state_d = DRAIN;
        end else if (si_valid) begin
          store   = 1'b1;
        end else begin
          trunc   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!si_valid) begin
          state_d = IDLE;
        end else if (gap_seen) begin
          start   = 1'b1;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      cnt         <= '0;
      len_q       <= '0;
      fill_q      <= 1'b0;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      gap_seen    <= 1'b0;
      po_data     <= '0;
      po_valid    <= 1'b0;
      pad_err     <= 1'b0;
      trunc_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef STI_RX_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      po_valid    <= done;
      pad_err     <= 1'b0;
      trunc_err   <= trunc;
      overrun_err <= ovr;
      if (start) begin
        len_q  <= cfg_length;
        fill_q <= cfg_fill;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
        shreg  <= bit_mask(cfg_msb, cfg_length, '0, si_data);
        cnt    <= CW'(1);
      end
      if (store) begin
        shreg <= shreg | bit_mask(msb_q, len_q, cnt, si_data);
        cnt   <= cnt + CW'(1);
      end
      if (done) begin
        po_data  <= ext[DW-1:0];
        pad_err  <= ext[16];
        // The gap on the completion cycle lets a new frame start straight out of DRAIN.
        gap_seen <= ~si_valid;
`ifdef STI_RX_FRAME_CNT_EN
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sti_deserializer.sv
// Directed + randomized bench for sti_deserializer against a behavioural frame model.
module tb_sti_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_fill, cfg_msb, cfg_low;
  logic [15:0] po_data;
  logic        po_valid, pad_err, trunc_err, overrun_err, busy;
`ifdef STI_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;

  sti_deserializer #(.DW(16), .CW(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .si_data     (si_data),
    .si_valid    (si_valid),
    .cfg_length  (cfg_length),
    .cfg_fill    (cfg_fill),
    .cfg_msb     (cfg_msb),
    .cfg_low     (cfg_low),
    .po_data     (po_data),
    .po_valid    (po_valid),
    .pad_err     (pad_err),
    .trunc_err   (trunc_err),
    .overrun_err (overrun_err),
    .busy        (busy)
`ifdef STI_RX_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: assemble frame word F from received order, then pick payload/padding by the frame rules.
  function automatic logic [16:0] model(input int n, input logic fill, input logic msb,
                                        input logic low, input logic [31:0] seq);
    logic [31:0] f;
    logic [31:0] padv;
    logic [15:0] d;
    int          lo;
    f    = '0;
    padv = '0;
    for (int k = 0; k < n; k++) begin
      if (msb) f[n-1-k] = seq[k];
      else     f[k]     = seq[k];
    end
    if (n == 8) begin
      d = low ? 16'(f << 8) : 16'(f);
    end else if (n == 16) begin
      d = 16'(f);
    end else begin
      lo = n - 16;
      if (fill) begin
        d    = 16'(f >> lo);
        padv = f & ((32'd1 << lo) - 32'd1);
      end else begin
        d    = 16'(f);
        padv = f >> 16;
      end
    end
    return {padv != 0, d};
  endfunction

  function automatic logic [31:0] to_seq(input int n, input logic msb, input logic [31:0] f);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s[k] = msb ? f[n-1-k] : f[k];
    return s;
  endfunction

  task automatic tick(input logic v, input logic d);
    si_valid = v;
    si_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input logic fill, input logic msb, input logic low,
                           input logic [31:0] seq, input int extra, input int trunc_n,
                           input bit scramble, output logic [15:0] got_data, output logic got_pad);
    logic [16:0] exp;
    int nb, busy_cnt, pv_cnt, ovr_cnt;
    exp        = model(n, fill, msb, low, seq);
    cfg_length = 2'(n / 8 - 1);
    cfg_fill   = fill;
    cfg_msb    = msb;
    cfg_low    = low;
    nb         = (trunc_n > 0) ? trunc_n : n;
    busy_cnt   = 0;
    pv_cnt     = 0;
    ovr_cnt    = 0;
    for (int k = 0; k < nb; k++) begin
      tick(1'b1, seq[k]);
      busy_cnt += int'(busy);
      pv_cnt   += int'(po_valid);
      ovr_cnt  += int'(overrun_err);
      if (scramble) begin
        cfg_length = 2'($urandom);
        cfg_fill   = 1'($urandom);
        cfg_msb    = 1'($urandom);
        cfg_low    = 1'($urandom);
      end
    end
    check("busy_during_bits", busy_cnt, nb);
    check("no_early_po_valid", pv_cnt, 0);
    if (trunc_n > 0) begin
      tick(1'b0, 1'b0);
      check("trunc_pulse", trunc_err, 1);
      check("trunc_no_po_valid", po_valid, 0);
      check("trunc_idle", busy, 0);
      tick(1'b0, 1'b0);
      check("trunc_single_cycle", trunc_err, 0);
      got_data = po_data;
      got_pad  = pad_err;
    end else begin
      tick(extra > 0, 1'($urandom));
      check("po_valid", po_valid, 1);
      check("po_data", po_data, exp[15:0]);
      check("pad_err", pad_err, exp[16]);
      check("busy_pulse_cycle", busy, 1);
      got_data = po_data;
      got_pad  = pad_err;
      exp_frames++;
      ovr_cnt += int'(overrun_err);
      for (int e = 1; e < extra; e++) begin
        tick(1'b1, 1'($urandom));
        ovr_cnt += int'(overrun_err);
        pv_cnt  += int'(po_valid);
      end
      tick(1'b0, 1'b0);
      ovr_cnt += int'(overrun_err);
      pv_cnt  += int'(po_valid);
      check("overrun_count", ovr_cnt, (extra > 0) ? 1 : 0);
      check("po_valid_single", pv_cnt, 0);
      check("drain_to_idle", busy, 0);
      check("po_data_hold", po_data, exp[15:0]);
      tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        p;
    int          n, extra, tn;

    reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
    cfg_length = 2'd0; cfg_fill = 1'b0; cfg_msb = 1'b0; cfg_low = 1'b0;
    @(posedge clk);
    #1;
    check("rst_po_valid", po_valid, 0);
    check("rst_po_data", po_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {pad_err, trunc_err, overrun_err}, 0);
    reset = 1'b0;
    tick(1'b0, 1'b0);

    run_frame(8, 1'b0, 1'b1, 1'b1, 32'h0000_00A5, 0, 0, 1'b0, d, p);
    check("dir8_data", d, 16'hA500);
    check("dir8_pad", p, 0);

    run_frame(16, 1'b0, 1'b0, 1'b0, to_seq(16, 1'b0, 32'h1234), 0, 0, 1'b0, d, p);
    check("dir16_data", d, 16'h1234);

    run_frame(24, 1'b0, 1'b1, 1'b0, to_seq(24, 1'b1, 32'h00BEEF), 0, 0, 1'b0, d, p);
    check("dir24_data", d, 16'hBEEF);
    check("dir24_pad", p, 0);
    run_frame(24, 1'b0, 1'b1, 1'b0, to_seq(24, 1'b1, 32'h08BEEF), 0, 0, 1'b0, d, p);
    check("dir24p_data", d, 16'hBEEF);
    check("dir24p_pad", p, 1);

    run_frame(32, 1'b1, 1'b0, 1'b0, $urandom, 0, 20, 1'b0, d, p);
    run_frame(8, 1'b0, 1'b1, 1'b0, to_seq(8, 1'b1, 32'h3C), 0, 0, 1'b0, d, p);
    check("after_trunc_data", d, 16'h003C);

    run_frame(16, 1'b0, 1'b1, 1'b0, to_seq(16, 1'b1, 32'hC3A5), 2, 0, 1'b0, d, p);
    check("overrun_frame_data", d, 16'hC3A5);

    cfg_length = 2'd3; cfg_fill = 1'b1; cfg_msb = 1'b0; cfg_low = 1'b0;
    for (int k = 0; k < 10; k++) tick(1'b1, 1'($urandom));
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_po_data", po_data, 0);
    check("midrst_flags", {po_valid, pad_err, trunc_err, overrun_err}, 0);
`ifdef STI_RX_FRAME_CNT_EN
    check("midrst_frame_cnt", frame_cnt, 0);
`endif
    exp_frames = 0;
    si_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b0, 1'b0);
    check("post_reset_no_trunc", trunc_err, 0);
    run_frame(16, 1'b0, 1'b1, 1'b0, to_seq(16, 1'b1, 32'h5A5A), 0, 0, 1'b0, d, p);
    check("post_reset_data", d, 16'h5A5A);
`ifdef STI_RX_FRAME_CNT_EN
    check("post_reset_frame_cnt", frame_cnt, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      n     = 8 * (1 + int'($urandom_range(0, 3)));
      extra = int'($urandom_range(0, 2));
      tn    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n - 1)) : 0;
      run_frame(n, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, extra, tn, 1'b1, d, p);
    end
`ifdef STI_RX_FRAME_CNT_EN
    check("final_frame_cnt", frame_cnt, exp_frames);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
